ddfs_freq_divider: RTL and testbench

- Programmable integer clock divider for the DDFS module.
- Produces a 50 %-duty output clock from clk_in.
- The divide ratio is selected by a 3-bit code.
- Ratio changes are glitch-free: a new code takes effect only at an output-period boundary, so downstream DDFS logic never sees a runt pulse.

---
 rtl/ddfs_freq_divider.sv | 50 +++++
 tb/tb_ddfs_freq_divider.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ddfs_freq_divider.sv
`default_nettype none
// ============================================================================
// Module      : ddfs_freq_divider
// Description : Programmable 50%-duty integer clock divider for the DDFS.
//               The half-period is H = 2^(code + BASE_SHIFT) clk_in cycles.
//               A new divide code is adopted only on the clk_out 1->0 edge,
//               so a period in progress always finishes at its old ratio.
// Revision    : 1.0 - initial release
// ============================================================================
module ddfs_freq_divider #(
    parameter int CNT_W      = 8,
    parameter int BASE_SHIFT = 0
) (
    input  logic       clk_in,
    input  logic       arstn,       // active-high asynchronous reset
    input  logic [2:0] freq_cntrl,
    output logic       clk_out
);

    logic [2:0]       active_sel;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] term;
    logic             at_term;

    // Terminal count of the half-period counter for the code in use (H-1).
    always_comb begin
        term    = (CNT_W'(1) << (32'(active_sel) + 32'(BASE_SHIFT))) - CNT_W'(1);
        at_term = (cnt == term);
    end

    // Half-period counter, output toggle and boundary-only code adoption.
    always_ff @(posedge clk_in or posedge arstn) begin
        if (arstn) begin
            cnt        <= '0;
            clk_out    <= 1'b0;
            active_sel <= 3'd0;
        end else if (at_term) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
            // The falling edge closes a period: only here may the ratio change.
            if (clk_out) begin
                active_sel <= freq_cntrl;
            end
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddfs_freq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddfs_freq_divider
// Description : Directed self-checking bench for ddfs_freq_divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddfs_freq_divider;

    logic       clk_in;
    logic       arstn;
    logic [2:0] freq_cntrl;
    logic       clk_out;

    int nvec;
    int nerr;

    ddfs_freq_divider #(
        .CNT_W      (8),
        .BASE_SHIFT (0)
    ) dut (
        .clk_in     (clk_in),
        .arstn      (arstn),
        .freq_cntrl (freq_cntrl),
        .clk_out    (clk_out)
    );

    // 100 MHz clock, rising edges at 5, 15, 25 ... ns.
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Wait (sampling on falling clk_in) until clk_out is seen going 1->0.
    task automatic wait_fall(output bit to);
        bit p;
        to = 1'b1;
        p  = clk_out;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_in);
            if (p && !clk_out) begin
                to = 1'b0;
                break;
            end
            p = clk_out;
        end
    endtask

    // Starting at a low sample (lo_start low samples already seen), count the
    // low then high samples of one period; returns at the next period's first
    // low sample so calls can be chained.
    task automatic measure(input int lo_start, output int lo, output int hi, output bit to);
        bit done;
        lo   = lo_start;
        hi   = 0;
        to   = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_in);
            if (clk_out) begin
                done = 1'b1;
                break;
            end
            lo++;
        end
        if (!done) to = 1'b1;
        hi   = 1;
        done = 1'b0;
        if (!to) begin
            for (int i = 0; i < 2000; i++) begin
                @(negedge clk_in);
                if (!clk_out) begin
                    done = 1'b1;
                    break;
                end
                hi++;
            end
            if (!done) to = 1'b1;
        end
    endtask

    task automatic test_reset;
        logic exp_seq [4];
        exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0};
        arstn      = 1'b1;
        freq_cntrl = 3'd0;
        #17;
        nvec++;
        if (clk_out !== 1'b0) begin
            nerr++;
            $display("FAIL reset_hold: clk_out=%b expected=0", clk_out);
        end
        #3 arstn = 1'b0;   // release at 20 ns, off the rising edge
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            nvec++;
            if (clk_out !== exp_seq[i]) begin
                nerr++;
                $display("FAIL div2_seq[%0d]: clk_out=%b expected=%b", i, clk_out, exp_seq[i]);
            end
        end
    endtask

    // Change the code right after a falling edge: the current period must
    // keep the old half-period, the following one must use the new one.
    task automatic test_change(input int old_h, input logic [2:0] new_f, input int new_h);
        int lo, hi;
        bit to;
        wait_fall(to);
        nvec++;
        if (to !== 1'b0) begin
            nerr++;
            $display("FAIL fall_timeout f=%0d: timeout=%b expected=0", new_f, to);
            return;
        end
        freq_cntrl = new_f;
        measure(1, lo, hi, to);
        nvec++;
        if (to !== 1'b0 || lo !== old_h || hi !== old_h) begin
            nerr++;
            $display("FAIL old_period f=%0d: lo=%0d hi=%0d to=%b expected lo=hi=%0d", new_f, lo, hi, to, old_h);
        end
        measure(1, lo, hi, to);
        nvec++;
        if (to !== 1'b0 || lo !== new_h || hi !== new_h) begin
            nerr++;
            $display("FAIL new_period f=%0d: lo=%0d hi=%0d to=%b expected lo=hi=%0d", new_f, lo, hi, to, new_h);
        end
    endtask

    // 3 -> 5 -> 1 within one /16 period; only the value at the boundary counts.
    task automatic test_jitter;
        int lo, hi;
        bit to;
        wait_fall(to);
        freq_cntrl = 3'd5;
        repeat (3) @(negedge clk_in);
        freq_cntrl = 3'd1;
        measure(4, lo, hi, to);
        nvec++;
        if (to !== 1'b0 || lo !== 8 || hi !== 8) begin
            nerr++;
            $display("FAIL jitter_cur: lo=%0d hi=%0d to=%b expected lo=hi=8", lo, hi, to);
        end
        measure(1, lo, hi, to);
        nvec++;
        if (to !== 1'b0 || lo !== 2 || hi !== 2) begin
            nerr++;
            $display("FAIL jitter_next: lo=%0d hi=%0d to=%b expected lo=hi=2", lo, hi, to);
        end
    endtask

    task automatic test_midreset;
        int lo, hi;
        bit seen;
        bit to;
        // Wait for a high sample while running at f=3.
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_in);
            if (clk_out) begin
                seen = 1'b1;
                break;
            end
        end
        nvec++;
        if (seen !== 1'b1) begin
            nerr++;
            $display("FAIL midreset_high: seen=%b expected=1", seen);
        end
        #2 arstn = 1'b1;
        #1;
        nvec++;
        if (clk_out !== 1'b0) begin
            nerr++;
            $display("FAIL midreset_async: clk_out=%b expected=0", clk_out);
        end
        @(negedge clk_in);
        #2 arstn = 1'b0;
        @(negedge clk_in);
        nvec++;
        if (clk_out !== 1'b1) begin
            nerr++;
            $display("FAIL post_reset_high: clk_out=%b expected=1", clk_out);
        end
        @(negedge clk_in);
        nvec++;
        if (clk_out !== 1'b0) begin
            nerr++;
            $display("FAIL post_reset_low: clk_out=%b expected=0", clk_out);
        end
        measure(1, lo, hi, to);
        nvec++;
        if (to !== 1'b0 || lo !== 8 || hi !== 8) begin
            nerr++;
            $display("FAIL post_reset_div16: lo=%0d hi=%0d to=%b expected lo=hi=8", lo, hi, to);
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_change(1, 3'd1, 2);    // /2  -> /4
        test_change(2, 3'd1, 2);    // same code, no timing change
        test_change(2, 3'd2, 4);    // /4  -> /8
        test_change(4, 3'd3, 8);    // /8  -> /16
        test_jitter();              // ends at /4
        test_change(2, 3'd3, 8);    // back to /16
        test_midreset();            // freq_cntrl stays 3
        test_change(8, 3'd7, 128);  // /16 -> /256
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
